// File: rtl/csr_trap_ctrl_pkg.sv
// Shared constants and types for the machine-mode CSR file and trap controller.
// CSR addresses, operation encoding, trap causes and implemented-bit masks.
package csr_trap_ctrl_pkg;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MIP     = 12'h344;

   typedef enum logic [1:0] {
      CSR_NONE  = 2'b00,
      CSR_WRITE = 2'b01,
      CSR_SET   = 2'b10,
      CSR_CLEAR = 2'b11
   } csr_op_e;

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      REDIRECT = 1'b1
   } trap_state_e;

   localparam logic [31:0] MCAUSE_MTI = 32'h8000_0007;
   localparam logic [31:0] MCAUSE_MEI = 32'h8000_000B;

   localparam int MSTATUS_MIE_BIT  = 3;
   localparam int MSTATUS_MPIE_BIT = 7;
   localparam int MIP_MTIP_BIT     = 7;
   localparam int MIP_MEIP_BIT     = 11;

   localparam logic [31:0] MSTATUS_MASK = 32'h0000_0088;
   localparam logic [31:0] MIE_MASK     = 32'h0000_0880;

endpackage

// File: rtl/csr_trap_ctrl_if.sv
// MW-stage CSR/mret bus between the pipeline (master) and the CSR/trap unit (slave).
// No handshake: every field is qualified by valid_m & ~stall_mw in the same cycle.
interface csr_trap_ctrl_if #(
   parameter int XLEN = 32
);
   logic            valid_m;
   logic            stall_mw;
   logic [XLEN-1:0] pc_m;
   logic [11:0]     csr_addr_m;
   logic [1:0]      csr_op_m;
   logic [XLEN-1:0] csr_wdata_m;
   logic            is_mret_m;
   logic [XLEN-1:0] csr_rdata_m;

   modport master (
      output valid_m, stall_mw, pc_m, csr_addr_m, csr_op_m, csr_wdata_m, is_mret_m,
      input  csr_rdata_m
   );

   modport slave (
      input  valid_m, stall_mw, pc_m, csr_addr_m, csr_op_m, csr_wdata_m, is_mret_m,
      output csr_rdata_m
   );
endinterface

// File: rtl/csr_trap_ctrl.sv
// Machine-mode CSR file and trap controller in the MW stage of the RV32I pipeline.
// Decides interrupt take / mret, drives the redirect, and applies CSR read-modify-writes.
module csr_trap_ctrl
   import csr_trap_ctrl_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   csr_trap_ctrl_if.slave    mw,
   input  logic              timer_irq_i,
   input  logic              ext_irq_i,
   output logic              redirect_o,
   output logic [XLEN-1:0]   redirect_pc_o,
   output logic [0:0]        state_dbg_o
);

   localparam logic [0:0] ST_RUN      = RUN;
   localparam logic [0:0] ST_REDIRECT = REDIRECT;

   logic [0:0]      state_q, state_d;
   logic [XLEN-1:0] mstatus_q, mstatus_d;
   logic [XLEN-1:0] mie_q, mie_d;
   logic [XLEN-1:0] mtvec_q, mtvec_d;
   logic [XLEN-1:0] mepc_q, mepc_d;
   logic [XLEN-1:0] mcause_q, mcause_d;
   logic [XLEN-1:0] mip_q, mip_d;

   logic            retire, irq_pend, take_irq, do_mret, csr_we, op_is_rs;
   logic [XLEN-1:0] irq_bits, rdata, wval, cause_val, tvec_base, trap_pc;
   csr_op_e         op;

   assign op = csr_op_e'(mw.csr_op_m);

   always_comb begin
      rdata = '0;
      case (mw.csr_addr_m)
         CSR_MSTATUS: rdata = mstatus_q;
         CSR_MIE:     rdata = mie_q;
         CSR_MTVEC:   rdata = mtvec_q;
         CSR_MEPC:    rdata = mepc_q;
         CSR_MCAUSE:  rdata = mcause_q;
         CSR_MIP:     rdata = mip_q;
         default:     rdata = '0;
      endcase
   end

   assign mw.csr_rdata_m = rdata;

   // Reset is folded in so no redirect escapes during a reset cycle.
   assign retire   = mw.valid_m & ~mw.stall_mw & (state_q == ST_RUN) & ~rst_i;
   assign irq_bits = mip_q & mie_q;
   assign irq_pend = mstatus_q[MSTATUS_MIE_BIT] & (|irq_bits);
   assign take_irq = retire & irq_pend;
   assign do_mret  = retire & ~irq_pend & mw.is_mret_m;
   assign op_is_rs = (op == CSR_SET) || (op == CSR_CLEAR);
   assign csr_we   = retire & ~irq_pend & ~mw.is_mret_m & (op != CSR_NONE)
                     & ~(op_is_rs & (mw.csr_wdata_m == '0));

   always_comb begin
      wval = rdata;
      case (op)
         CSR_WRITE: wval = mw.csr_wdata_m;
         CSR_SET:   wval = rdata | mw.csr_wdata_m;
         CSR_CLEAR: wval = rdata & ~mw.csr_wdata_m;
         default:   wval = rdata;
      endcase
   end

   assign cause_val = irq_bits[MIP_MEIP_BIT] ? XLEN'(MCAUSE_MEI) : XLEN'(MCAUSE_MTI);
   assign tvec_base = {mtvec_q[XLEN-1:2], 2'b00};
   assign trap_pc   = mtvec_q[0] ? tvec_base + XLEN'({cause_val[3:0], 2'b00}) : tvec_base;

   assign redirect_o    = take_irq | do_mret;
   assign redirect_pc_o = take_irq ? trap_pc : (do_mret ? mepc_q : '0);
   assign state_dbg_o   = state_q;

   always_comb begin
      state_d   = (state_q == ST_REDIRECT) ? ST_RUN : state_q;
      mstatus_d = mstatus_q;
      mie_d     = mie_q;
      mtvec_d   = mtvec_q;
      mepc_d    = mepc_q;
      mcause_d  = mcause_q;
      mip_d     = '0;
      mip_d[MIP_MTIP_BIT] = timer_irq_i;
      mip_d[MIP_MEIP_BIT] = ext_irq_i;
      if (take_irq) begin
         // The MW instruction is abandoned; mepc points at it so mret re-executes it.
         mepc_d    = mw.pc_m & ~XLEN'(3);
         mcause_d  = cause_val;
         mstatus_d = '0;
         mstatus_d[MSTATUS_MPIE_BIT] = mstatus_q[MSTATUS_MIE_BIT];
         state_d   = ST_REDIRECT;
      end else if (do_mret) begin
         mstatus_d = '0;
         mstatus_d[MSTATUS_MIE_BIT]  = mstatus_q[MSTATUS_MPIE_BIT];
         mstatus_d[MSTATUS_MPIE_BIT] = 1'b1;
         state_d   = ST_REDIRECT;
      end else if (csr_we) begin
         case (mw.csr_addr_m)
            CSR_MSTATUS: mstatus_d = wval & XLEN'(MSTATUS_MASK);
            CSR_MIE:     mie_d     = wval & XLEN'(MIE_MASK);
            CSR_MTVEC:   mtvec_d   = wval & ~XLEN'(2);
            CSR_MEPC:    mepc_d    = wval & ~XLEN'(3);
            CSR_MCAUSE:  mcause_d  = wval;
            default:     ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_RUN;
         mstatus_q <= '0;
         mie_q     <= '0;
         mtvec_q   <= MTVEC_RESET;
         mepc_q    <= '0;
         mcause_q  <= '0;
         mip_q     <= '0;
      end else begin
         state_q   <= state_d;
         mstatus_q <= mstatus_d;
         mie_q     <= mie_d;
         mtvec_q   <= mtvec_d;
         mepc_q    <= mepc_d;
         mcause_q  <= mcause_d;
         mip_q     <= mip_d;
      end
   end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Self-checking bench for csr_trap_ctrl: directed trap/mret scenarios plus a
// randomized run checked against a behavioural model of the CSR/trap rules.
module tb_csr_trap_ctrl;

   localparam logic [31:0] MTVEC_RST = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        timer_irq_i = 1'b0;
   logic        ext_irq_i = 1'b0;
   logic        redirect_o;
   logic [31:0] redirect_pc_o;
   logic [0:0]  state_dbg_o;

   int n_cmp = 0;
   int n_err = 0;

   csr_trap_ctrl_if #(.XLEN(32)) mw_if ();

   csr_trap_ctrl #(.XLEN(32), .MTVEC_RESET(MTVEC_RST)) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .mw            (mw_if),
      .timer_irq_i   (timer_irq_i),
      .ext_irq_i     (ext_irq_i),
      .redirect_o    (redirect_o),
      .redirect_pc_o (redirect_pc_o),
      .state_dbg_o   (state_dbg_o)
   );

   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      mw_if.valid_m     = 1'b0;
      mw_if.stall_mw    = 1'b0;
      mw_if.pc_m        = '0;
      mw_if.csr_addr_m  = '0;
      mw_if.csr_op_m    = 2'b00;
      mw_if.csr_wdata_m = '0;
      mw_if.is_mret_m   = 1'b0;
   endtask

   task automatic do_reset();
      idle_in();
      timer_irq_i = 1'b0;
      ext_irq_i   = 1'b0;
      rst_i = 1'b1;
      step();
      step();
      rst_i = 1'b0;
   endtask

   task automatic csr_cmd(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] wd);
      idle_in();
      mw_if.valid_m     = 1'b1;
      mw_if.pc_m        = 32'h0000_0020;
      mw_if.csr_addr_m  = addr;
      mw_if.csr_op_m    = op;
      mw_if.csr_wdata_m = wd;
      step();
      idle_in();
   endtask

   // ---------------- behavioural reference model ----------------
   logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause, m_mip;
   bit          m_redir;

   function automatic logic [31:0] m_read(input logic [11:0] a);
      case (a)
         12'h300: return m_mstatus;
         12'h304: return m_mie;
         12'h305: return m_mtvec;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         12'h344: return m_mip;
         default: return 32'h0;
      endcase
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [11:0] addrs [6];
      logic [31:0] exps  [6];
      addrs = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344};
      exps  = '{32'h0, 32'h0, MTVEC_RST, 32'h0, 32'h0, 32'h0};
      do_reset();
      mw_if.valid_m = 1'b1;
      mw_if.is_mret_m = 1'b1;
      rst_i = 1'b1;
      #1;
      n_cmp++;
      if (redirect_o !== 1'b0) begin
         n_err++; $display("FAIL reset_mret_blocked: got %b expected 0", redirect_o);
      end
      step();
      rst_i = 1'b0;
      idle_in();
      n_cmp++;
      if (state_dbg_o !== 1'b0) begin
         n_err++; $display("FAIL reset_state: got %b expected 0", state_dbg_o);
      end
      n_cmp++;
      if (redirect_o !== 1'b0 || redirect_pc_o !== 32'h0) begin
         n_err++; $display("FAIL reset_redirect: got %b/%h expected 0/0", redirect_o, redirect_pc_o);
      end
      for (int i = 0; i < 6; i++) begin
         mw_if.csr_addr_m = addrs[i];
         #1;
         n_cmp++;
         if (mw_if.csr_rdata_m !== exps[i]) begin
            n_err++;
            $display("FAIL reset_csr_%h: got %h expected %h", addrs[i], mw_if.csr_rdata_m, exps[i]);
         end
      end
   endtask

   task automatic test_trap_mret_back_to_back();
      do_reset();
      csr_cmd(12'h305, 2'b01, 32'h0000_0100);
      csr_cmd(12'h304, 2'b10, 32'h0000_0800);
      csr_cmd(12'h300, 2'b10, 32'h0000_0008);
      ext_irq_i = 1'b1;
      step();
      mw_if.valid_m = 1'b1;
      mw_if.pc_m    = 32'h0000_0040;
      #1;
      n_cmp++;
      if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h0000_0100) begin
         n_err++; $display("FAIL ext_trap: got %b/%h expected 1/00000100", redirect_o, redirect_pc_o);
      end
      step();
      idle_in();
      mw_if.csr_addr_m = 12'h341;
      #1;
      n_cmp++;
      if (mw_if.csr_rdata_m !== 32'h40) begin
         n_err++; $display("FAIL ext_mepc: got %h expected 00000040", mw_if.csr_rdata_m);
      end
      mw_if.csr_addr_m = 12'h342;
      #1;
      n_cmp++;
      if (mw_if.csr_rdata_m !== 32'h8000_000B) begin
         n_err++; $display("FAIL ext_mcause: got %h expected 8000000b", mw_if.csr_rdata_m);
      end
      mw_if.csr_addr_m = 12'h300;
      #1;
      n_cmp++;
      if (mw_if.csr_rdata_m !== 32'h80) begin
         n_err++; $display("FAIL ext_mstatus: got %h expected 00000080", mw_if.csr_rdata_m);
      end
      step();
      mw_if.valid_m   = 1'b1;
      mw_if.is_mret_m = 1'b1;
      mw_if.pc_m      = 32'h0000_0104;
      #1;
      n_cmp++;
      if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h40) begin
         n_err++; $display("FAIL mret_redirect: got %b/%h expected 1/00000040", redirect_o, redirect_pc_o);
      end
      step();
      idle_in();
      mw_if.valid_m    = 1'b1;
      mw_if.pc_m       = 32'h0000_0108;
      mw_if.csr_addr_m = 12'h300;
      #1;
      n_cmp++;
      if (mw_if.csr_rdata_m !== 32'h88) begin
         n_err++; $display("FAIL mret_mstatus: got %h expected 00000088", mw_if.csr_rdata_m);
      end
      n_cmp++;
      if (redirect_o !== 1'b0) begin
         n_err++; $display("FAIL b2b_early_trap: got %b expected 0", redirect_o);
      end
      step();
      mw_if.pc_m = 32'h0000_0040;
      #1;
      n_cmp++;
      if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h100) begin
         n_err++; $display("FAIL b2b_retake: got %b/%h expected 1/00000100", redirect_o, redirect_pc_o);
      end
      step();
      idle_in();
      ext_irq_i = 1'b0;
      step();
   endtask

   task automatic test_vectored();
      do_reset();
      csr_cmd(12'h305, 2'b01, 32'h0000_0101);
      csr_cmd(12'h304, 2'b01, 32'h0000_0880);
      timer_irq_i = 1'b1;
      ext_irq_i   = 1'b1;
      csr_cmd(12'h300, 2'b01, 32'h0000_0008);
      mw_if.valid_m = 1'b1;
      mw_if.pc_m    = 32'h0000_0080;
      #1;
      n_cmp++;
      if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h0000_012C) begin
         n_err++; $display("FAIL vec_target: got %b/%h expected 1/0000012c", redirect_o, redirect_pc_o);
      end
      step();
      idle_in();
      mw_if.csr_addr_m = 12'h342;
      #1;
      n_cmp++;
      if (mw_if.csr_rdata_m !== 32'h8000_000B) begin
         n_err++; $display("FAIL vec_cause: got %h expected 8000000b", mw_if.csr_rdata_m);
      end
      n_cmp++;
      if (state_dbg_o !== 1'b1) begin
         n_err++; $display("FAIL vec_state: got %b expected 1", state_dbg_o);
      end
      step();
   endtask

   task automatic test_suppress();
      do_reset();
      csr_cmd(12'h304, 2'b01, 32'h0000_0080);
      timer_irq_i = 1'b1;
      csr_cmd(12'h300, 2'b01, 32'h0000_0008);
      mw_if.valid_m     = 1'b1;
      mw_if.pc_m        = 32'h0000_0300;
      mw_if.csr_addr_m  = 12'h300;
      mw_if.csr_op_m    = 2'b11;
      mw_if.csr_wdata_m = 32'h8;
      #1;
      n_cmp++;
      if (mw_if.csr_rdata_m !== 32'h8) begin
         n_err++; $display("FAIL supp_rdata: got %h expected 00000008", mw_if.csr_rdata_m);
      end
      n_cmp++;
      if (redirect_o !== 1'b1 || redirect_pc_o !== MTVEC_RST) begin
         n_err++; $display("FAIL supp_trap: got %b/%h expected 1/%h", redirect_o, redirect_pc_o, MTVEC_RST);
      end
      step();
      idle_in();
      mw_if.csr_addr_m = 12'h300;
      #1;
      n_cmp++;
      if (mw_if.csr_rdata_m !== 32'h80) begin
         n_err++; $display("FAIL supp_mstatus: got %h expected 00000080", mw_if.csr_rdata_m);
      end
      step();
   endtask

   task automatic test_stall_and_reset();
      do_reset();
      csr_cmd(12'h304, 2'b01, 32'h0000_0080);
      timer_irq_i = 1'b1;
      csr_cmd(12'h300, 2'b10, 32'h0000_0008);
      mw_if.valid_m  = 1'b1;
      mw_if.stall_mw = 1'b1;
      mw_if.pc_m     = 32'h0000_0200;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++;
         if (redirect_o !== 1'b0) begin
            n_err++; $display("FAIL stall_cycle%0d: got %b expected 0", i, redirect_o);
         end
         step();
      end
      mw_if.stall_mw = 1'b0;
      #1;
      n_cmp++;
      if (redirect_o !== 1'b1 || redirect_pc_o !== MTVEC_RST) begin
         n_err++; $display("FAIL stall_release: got %b/%h expected 1/%h", redirect_o, redirect_pc_o, MTVEC_RST);
      end
      step();
      idle_in();
      timer_irq_i = 1'b0;
      rst_i = 1'b1;
      #1;
      n_cmp++;
      if (state_dbg_o !== 1'b1 || redirect_o !== 1'b0) begin
         n_err++; $display("FAIL rst_in_redirect: got state %b redirect %b expected 1/0", state_dbg_o, redirect_o);
      end
      step();
      rst_i = 1'b0;
      #1;
      n_cmp++;
      if (state_dbg_o !== 1'b0 || redirect_pc_o !== 32'h0) begin
         n_err++; $display("FAIL rst_after_redirect: got %b/%h expected 0/0", state_dbg_o, redirect_pc_o);
      end
      mw_if.csr_addr_m = 12'h300;
      #1;
      n_cmp++;
      if (mw_if.csr_rdata_m !== 32'h0) begin
         n_err++; $display("FAIL rst_mstatus: got %h expected 0", mw_if.csr_rdata_m);
      end
      mw_if.csr_addr_m = 12'h341;
      #1;
      n_cmp++;
      if (mw_if.csr_rdata_m !== 32'h0) begin
         n_err++; $display("FAIL rst_mepc: got %h expected 0", mw_if.csr_rdata_m);
      end
      mw_if.csr_addr_m = 12'h305;
      #1;
      n_cmp++;
      if (mw_if.csr_rdata_m !== MTVEC_RST) begin
         n_err++; $display("FAIL rst_mtvec: got %h expected %h", mw_if.csr_rdata_m, MTVEC_RST);
      end
   endtask

   task automatic test_random();
      logic [11:0] addr_tab [8];
      logic [31:0] wd_tab   [7];
      logic [31:0] exp_rd, exp_pc, cause, base, nv;
      logic        exp_rd_o, slot, pend;
      logic [31:0] hit;
      addr_tab = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'h340, 12'h7C0};
      wd_tab   = '{32'h0, 32'h8, 32'h88, 32'h880, 32'h80, 32'h800, 32'h0000_0201};
      do_reset();
      m_mstatus = 32'h0; m_mie = 32'h0; m_mtvec = MTVEC_RST;
      m_mepc = 32'h0; m_mcause = 32'h0; m_mip = 32'h0; m_redir = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         mw_if.valid_m    = ($urandom_range(0, 9) != 0);
         mw_if.stall_mw   = ($urandom_range(0, 7) == 0);
         mw_if.is_mret_m  = ($urandom_range(0, 15) == 0);
         mw_if.csr_op_m   = mw_if.is_mret_m ? 2'b00 : 2'($urandom_range(0, 3));
         mw_if.csr_addr_m = addr_tab[$urandom_range(0, 7)];
         mw_if.csr_wdata_m = ($urandom_range(0, 3) == 0) ? $urandom : wd_tab[$urandom_range(0, 6)];
         mw_if.pc_m       = $urandom;
         if ($urandom_range(0, 7) == 0) timer_irq_i = ~timer_irq_i;
         if ($urandom_range(0, 7) == 0) ext_irq_i = ~ext_irq_i;
         #1;
         exp_rd   = m_read(mw_if.csr_addr_m);
         exp_rd_o = 1'b0;
         exp_pc   = 32'h0;
         slot = mw_if.valid_m && !mw_if.stall_mw && !m_redir;
         hit  = m_mip & m_mie;
         pend = (m_mstatus[3] == 1'b1) && (hit != 0);
         if (slot && pend) begin
            cause = (hit[11] == 1'b1) ? 32'h8000_000B : 32'h8000_0007;
            base  = m_mtvec & ~32'h3;
            exp_pc = (m_mtvec[0] == 1'b1) ? base + 4 * (cause % 16) : base;
            exp_rd_o = 1'b1;
         end else if (slot && mw_if.is_mret_m) begin
            exp_pc = m_mepc;
            exp_rd_o = 1'b1;
         end
         n_cmp++;
         if (mw_if.csr_rdata_m !== exp_rd) begin
            n_err++; $display("FAIL rnd_rdata cyc%0d: got %h expected %h", cyc, mw_if.csr_rdata_m, exp_rd);
         end
         n_cmp++;
         if (redirect_o !== exp_rd_o || redirect_pc_o !== exp_pc) begin
            n_err++;
            $display("FAIL rnd_redirect cyc%0d: got %b/%h expected %b/%h", cyc, redirect_o, redirect_pc_o, exp_rd_o, exp_pc);
         end
         n_cmp++;
         if (state_dbg_o !== 1'(m_redir)) begin
            n_err++; $display("FAIL rnd_state cyc%0d: got %b expected %b", cyc, state_dbg_o, m_redir);
         end
         // model update for the coming edge
         if (slot && pend) begin
            m_mepc    = mw_if.pc_m & ~32'h3;
            m_mcause  = cause;
            m_mstatus = 32'h80;
         end else if (slot && mw_if.is_mret_m) begin
            m_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
         end else if (slot && mw_if.csr_op_m != 2'b00 &&
                      !(mw_if.csr_op_m != 2'b01 && mw_if.csr_wdata_m == 0)) begin
            if (mw_if.csr_op_m == 2'b01)      nv = mw_if.csr_wdata_m;
            else if (mw_if.csr_op_m == 2'b10) nv = exp_rd | mw_if.csr_wdata_m;
            else                              nv = exp_rd & ~mw_if.csr_wdata_m;
            case (mw_if.csr_addr_m)
               12'h300: m_mstatus = nv & 32'h88;
               12'h304: m_mie     = nv & 32'h880;
               12'h305: m_mtvec   = nv & ~32'h2;
               12'h341: m_mepc    = nv & ~32'h3;
               12'h342: m_mcause  = nv;
               default: ;
            endcase
         end
         m_redir = exp_rd_o;
         m_mip = (timer_irq_i ? 32'h80 : 32'h0) | (ext_irq_i ? 32'h800 : 32'h0);
         step();
      end
      idle_in();
   endtask

   initial begin
      idle_in();
      test_reset();
      test_trap_mret_back_to_back();
      test_vectored();
      test_suppress();
      test_stall_and_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
